// File: rtl/bmem_axi_writer.sv
// rtl/bmem_axi_writer.sv - bmem write port to single-beat AXI4 write bridge
// One request captured at a time, issued on AW/W, completed on B with a bmem_resp pulse.
module bmem_axi_writer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             axi_clk,
  input  logic             rst,
  input  logic             bmem_wr_en,
  input  logic [63:0]      bmem_wr_data,
  input  logic [31:0]      bmem_wr_addr,
  output logic             bmem_resp,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_awaddr,
  output logic [7:0]       m_axi_awlen,
  output logic [2:0]       m_axi_awsize,
  output logic [1:0]       m_axi_awburst,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  output logic [63:0]      m_axi_wdata,
  output logic [7:0]       m_axi_wstrb,
  output logic             m_axi_wlast,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  input  logic [1:0]       m_axi_bresp,
  output logic             err_bresp,
  output logic             err_misalign,
  output logic             err_timeout,
  output logic [CNT_W-1:0] wr_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, RESP} state_t;

  state_t        state;
  logic          aw_done;
  logic          w_done;
  logic [TW-1:0] tcnt;
  logic          aw_hs;
  logic          w_hs;
  logic          aw_fin;
  logic          w_fin;

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = 1'b1;

  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes on this edge.
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  always_ff @(posedge axi_clk) begin
    if (!rst) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      tcnt          <= '0;
      bmem_resp     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      err_bresp     <= 1'b0;
      err_misalign  <= 1'b0;
      err_timeout   <= 1'b0;
      wr_count      <= '0;
    end else begin
      bmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (bmem_wr_en) begin
            m_axi_awaddr  <= {bmem_wr_addr[31:3], 3'b000};
            m_axi_wdata   <= bmem_wr_data;
            if (bmem_wr_addr[2:0] != 3'b000) err_misalign <= 1'b1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tcnt          <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            bmem_resp    <= 1'b1;
            wr_count     <= wr_count + CNT_W'(1);
            if (m_axi_bresp != 2'b00) err_bresp <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog only flags; the outstanding handshakes are left to finish.
      if (state == ISSUE || state == WAIT_B) begin
        if (tcnt < TW'(TIMEOUT_CYCLES)) begin
          tcnt <= tcnt + TW'(1);
          if (tcnt == TW'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmem_axi_writer.sv
// tb/tb_bmem_axi_writer.sv - scoreboard bench for bmem_axi_writer
module tb_bmem_axi_writer;

  logic        axi_clk = 1'b0;
  logic        rst = 1'b0;
  logic        bmem_wr_en = 1'b0;
  logic [63:0] bmem_wr_data = '0;
  logic [31:0] bmem_wr_addr = '0;
  logic        bmem_resp;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b1;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b1;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid = 1'b1;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        err_bresp;
  logic        err_misalign;
  logic        err_timeout;
  logic [15:0] wr_count;

  always #5 axi_clk = ~axi_clk;

  bmem_axi_writer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .axi_clk(axi_clk), .rst(rst),
    .bmem_wr_en(bmem_wr_en), .bmem_wr_data(bmem_wr_data), .bmem_wr_addr(bmem_wr_addr),
    .bmem_resp(bmem_resp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .err_bresp(err_bresp), .err_misalign(err_misalign), .err_timeout(err_timeout),
    .wr_count(wr_count)
  );

  typedef struct {
    int   cnt;
    logic eb;
    logic em;
    logic et;
  } resp_t;

  int          total = 0;
  int          bad = 0;
  int          aw_n = 0;
  int          w_n = 0;
  int          r_n = 0;
  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  resp_t       r_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or response.
  always @(negedge axi_clk) begin : monitor
    logic [31:0] ea;
    logic [63:0] ed;
    resp_t       er;
    if (rst === 1'b1 && m_axi_awvalid === 1'b1 && m_axi_awready === 1'b1) begin
      aw_n++;
      if (aw_q.size() == 0) begin
        total++; bad++;
        $display("FAIL aw_unexpected: got awaddr %0h expected no handshake", m_axi_awaddr);
      end else begin
        ea = aw_q.pop_front();
        chk("awaddr", m_axi_awaddr, ea);
        chk("awlen", m_axi_awlen, 0);
        chk("awsize", m_axi_awsize, 3);
        chk("awburst", m_axi_awburst, 1);
      end
    end
    if (rst === 1'b1 && m_axi_wvalid === 1'b1 && m_axi_wready === 1'b1) begin
      w_n++;
      if (w_q.size() == 0) begin
        total++; bad++;
        $display("FAIL w_unexpected: got wdata %0h expected no handshake", m_axi_wdata);
      end else begin
        ed = w_q.pop_front();
        chk("wdata", m_axi_wdata, ed);
        chk("wstrb", m_axi_wstrb, 8'hFF);
        chk("wlast", m_axi_wlast, 1);
      end
    end
    if (rst === 1'b1 && bmem_resp === 1'b1) begin
      r_n++;
      if (r_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got bmem_resp 1 expected 0");
      end else begin
        er = r_q.pop_front();
        chk("resp_wr_count", wr_count, er.cnt);
        chk("resp_err_bresp", err_bresp, er.eb);
        chk("resp_err_misalign", err_misalign, er.em);
        chk("resp_err_timeout", err_timeout, er.et);
      end
    end
  end

  task automatic do_reset;
    rst = 1'b0;
    bmem_wr_en = 1'b0;
    @(posedge axi_clk);
    #1 rst = 1'b1;
    aw_q.delete();
    w_q.delete();
    r_q.delete();
  endtask

  // Called 1ns after a rising edge; lat counts cycles after the capture edge.
  task automatic xfer(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] br,
                      input int cnt, input logic eb, input logic em, input logic et,
                      input bit hold, output int lat);
    resp_t r;
    r.cnt = cnt; r.eb = eb; r.em = em; r.et = et;
    aw_q.push_back({addr[31:3], 3'b000});
    w_q.push_back(data);
    r_q.push_back(r);
    m_axi_bresp  = br;
    bmem_wr_addr = addr;
    bmem_wr_data = data;
    bmem_wr_en   = 1'b1;
    @(posedge axi_clk);
    lat = 0;
    do begin
      @(negedge axi_clk);
      lat++;
    end while (bmem_resp !== 1'b1 && lat < 60);
    if (bmem_resp !== 1'b1) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no bmem_resp after %0d cycles expected a pulse", lat);
    end
    @(posedge axi_clk);
    #1;
    if (!hold) bmem_wr_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int a0, w0, r0;
    int found;

    do_reset;
    @(negedge axi_clk);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_resp", bmem_resp, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_errs", {err_bresp, err_misalign, err_timeout}, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    @(posedge axi_clk);
    #1;

    // single write, everything ready
    xfer(32'h1000_0008, 64'hDEAD_BEEF_0123_4567, 2'b00, 1, 0, 0, 0, 0, lat);
    chk("single_latency", lat, 3);

    // skewed channels: wready from the first issue cycle, awready five cycles later
    do_reset;
    m_axi_awready = 1'b0;
    r0 = r_n;
    fork
      xfer(32'h3000_0040, 64'h1111_2222_3333_4444, 2'b00, 1, 0, 0, 0, 0, lat);
      begin
        repeat (6) @(posedge axi_clk);
        #1 m_axi_awready = 1'b1;
      end
      begin
        repeat (2) @(posedge axi_clk);
        repeat (3) begin
          @(negedge axi_clk);
          chk("skew_wvalid_dropped", m_axi_wvalid, 0);
          chk("skew_awvalid_held", m_axi_awvalid, 1);
          chk("skew_awaddr_stable", m_axi_awaddr, 32'h3000_0040);
          chk("skew_bready_low", m_axi_bready, 0);
        end
      end
    join
    chk("skew_latency", lat, 8);
    chk("skew_one_resp", r_n - r0, 1);

    // error response, then a misaligned write
    do_reset;
    xfer(32'h5000_0010, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 1, 1, 0, 0, 0, lat);
    chk("slverr_latency", lat, 3);
    xfer(32'h2000_0005, 64'h0123_4567_89AB_CDEF, 2'b00, 2, 1, 1, 0, 0, lat);
    chk("misalign_latency", lat, 3);

    // back-to-back with bmem_wr_en held throughout
    do_reset;
    a0 = aw_n; w0 = w_n; r0 = r_n;
    for (int i = 0; i < 4; i++) begin
      xfer(32'h6000_0000 + 32'(i * 8), 64'hA5A5_0000_0000_0000 + 64'(i), 2'b00,
           i + 1, 0, 0, 0, (i < 3), lat);
      chk("b2b_latency", lat, 3);
    end
    chk("b2b_aw_count", aw_n - a0, 4);
    chk("b2b_w_count", w_n - w0, 4);
    chk("b2b_resp_count", r_n - r0, 4);

    // reset while waiting for B (wr_count is 4 here, misalign set by this write)
    m_axi_bvalid = 1'b0;
    aw_q.push_back(32'h7000_0000);
    w_q.push_back(64'h7777_7777_7777_7777);
    bmem_wr_addr = 32'h7000_0003;
    bmem_wr_data = 64'h7777_7777_7777_7777;
    bmem_wr_en   = 1'b1;
    @(posedge axi_clk);
    #1 bmem_wr_en = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge axi_clk);
      if (m_axi_bready === 1'b1) found = 1;
    end
    chk("mid_reached_wait_b", found, 1);
    rst = 1'b0;
    @(posedge axi_clk);
    #1 rst = 1'b1;
    @(negedge axi_clk);
    chk("mid_awvalid", m_axi_awvalid, 0);
    chk("mid_wvalid", m_axi_wvalid, 0);
    chk("mid_bready", m_axi_bready, 0);
    chk("mid_resp", bmem_resp, 0);
    chk("mid_wr_count", wr_count, 0);
    chk("mid_err_misalign", err_misalign, 0);
    chk("mid_awaddr", m_axi_awaddr, 0);
    m_axi_bvalid = 1'b1;
    @(posedge axi_clk);
    #1;
    xfer(32'h7000_0100, 64'h8888_9999_AAAA_BBBB, 2'b00, 1, 0, 0, 0, 0, lat);
    chk("mid_next_latency", lat, 3);

    // timeout: awready held low for 20 cycles
    do_reset;
    m_axi_awready = 1'b0;
    fork
      xfer(32'h4000_0000, 64'hCAFE_F00D_CAFE_F00D, 2'b00, 1, 0, 0, 1, 0, lat);
      begin
        repeat (21) @(posedge axi_clk);
        #1 m_axi_awready = 1'b1;
      end
      begin
        @(posedge axi_clk);
        for (int k = 1; k <= 9; k++) begin
          @(negedge axi_clk);
          if (k == 7) chk("timeout_not_yet", err_timeout, 0);
          if (k == 9) begin
            chk("timeout_set", err_timeout, 1);
            chk("timeout_awvalid_held", m_axi_awvalid, 1);
          end
        end
      end
    join
    chk("timeout_latency", lat, 23);
    @(negedge axi_clk);
    chk("timeout_sticky", err_timeout, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
